// File: rtl/enemy_bullet_pool_pkg.sv
`default_nettype none
// ============================================================================
// Package     : enemy_bullet_pkg
// Description : Shared screen constants, colour/slot types and the
//               bullet-versus-player box overlap test.
// Options     : ENEMY_BULLET_AIMED_SHOT_EN adds a per-slot dx field.
// Revision    : 1.0 - initial release
// ============================================================================
package enemy_bullet_pkg;

    localparam int c_SCREEN_W = 640;
    localparam int c_SCREEN_H = 480;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
`ifdef ENEMY_BULLET_AIMED_SHOT_EN
        logic [1:0] dx;     // 2'b01 = +1, 2'b11 = -1, 2'b00 = straight down
`endif
    } slot_t;

    // Axis-aligned box overlap; every sum is carried in 11 bits so that
    // coordinates near the 10-bit limit cannot wrap.
    function automatic logic overlap(
        input logic [9:0]  bx,
        input logic [9:0]  by,
        input logic [9:0]  px,
        input logic [9:0]  py,
        input logic [10:0] bw,
        input logic [10:0] bh,
        input logic [10:0] pw,
        input logic [10:0] ph
    );
        logic [10:0] bx11;
        logic [10:0] by11;
        logic [10:0] px11;
        logic [10:0] py11;
        bx11 = {1'b0, bx};
        by11 = {1'b0, by};
        px11 = {1'b0, px};
        py11 = {1'b0, py};
        return (bx11 < px11 + pw) && (bx11 + bw > px11) &&
               (by11 < py11 + ph) && (by11 + bh > py11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_bullet_pool_bullet_slot.sv
`default_nettype none
// ============================================================================
// Module      : bullet_slot
// Description : One enemy bullet slot: load on fire, move down on each
//               frame tick, free on leaving the screen or hitting the
//               player, and report whether the scan pixel falls on it.
// Options     : ENEMY_BULLET_AIMED_SHOT_EN adds horizontal drift (dx).
// Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot
    import enemy_bullet_pkg::*;
#(
    parameter int BULLET_W = 4,
    parameter int BULLET_H = 12,
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 32,
    parameter int SCREEN_W = c_SCREEN_W,
    parameter int SCREEN_H = c_SCREEN_H,
    parameter int SPEED    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_tick,
    input  logic       i_load,
    input  logic [9:0] i_load_x,
    input  logic [9:0] i_load_y,
`ifdef ENEMY_BULLET_AIMED_SHOT_EN
    input  logic [1:0] i_load_dx,
`endif
    input  logic [9:0] i_p_x,
    input  logic [9:0] i_p_y,
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    output logic       o_valid,
    output logic       o_hit,
    output logic       o_pix_on
);

    slot_t       r_slot;
    logic [10:0] w_y_new;
    logic [9:0]  w_x_new;
    logic        w_off;
    logic        w_hit;
    logic        w_pix_on;

    // Post-move position and the two ways a live slot can retire on a tick.
    always_comb begin
        w_y_new = {1'b0, r_slot.y} + 11'(SPEED);
        w_x_new = r_slot.x;
`ifdef ENEMY_BULLET_AIMED_SHOT_EN
        case (r_slot.dx)
            2'b01: if ({1'b0, r_slot.x} < 11'(SCREEN_W - BULLET_W)) w_x_new = r_slot.x + 10'd1;
            2'b11: if (r_slot.x != 10'd0) w_x_new = r_slot.x - 10'd1;
            default: w_x_new = r_slot.x;
        endcase
`endif
        w_off = (w_y_new >= 11'(SCREEN_H));
        // Leaving the screen takes precedence, so an off-screen move never scores.
        w_hit = r_slot.valid && i_frame_tick && !w_off &&
                overlap(w_x_new, w_y_new[9:0], i_p_x, i_p_y,
                        11'(BULLET_W), 11'(BULLET_H), 11'(PLAYER_W), 11'(PLAYER_H));
    end

    // Slot state: load only ever targets a free slot, so it cannot race a move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot.valid <= 1'b1;
            r_slot.x     <= i_load_x;
            r_slot.y     <= i_load_y;
`ifdef ENEMY_BULLET_AIMED_SHOT_EN
            r_slot.dx    <= i_load_dx;
`endif
        end else if (r_slot.valid && i_frame_tick) begin
            if (w_off || w_hit) begin
                r_slot.valid <= 1'b0;
            end else begin
                r_slot.x <= w_x_new;
                r_slot.y <= w_y_new[9:0];
            end
        end
    end

    // Current scan pixel lies inside this bullet's rectangle.
    always_comb begin
        w_pix_on = r_slot.valid &&
                   (i_pix_x >= r_slot.x) &&
                   ({1'b0, i_pix_x} < {1'b0, r_slot.x} + 11'(BULLET_W)) &&
                   (i_pix_y >= r_slot.y) &&
                   ({1'b0, i_pix_y} < {1'b0, r_slot.y} + 11'(BULLET_H));
    end

    assign o_valid  = r_slot.valid;
    assign o_hit    = w_hit;
    assign o_pix_on = w_pix_on;

endmodule
`default_nettype wire

// File: rtl/enemy_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module      : enemy_bullet_pool
// Description : Fixed pool of downward-moving enemy bullets with a
//               req/ack fire handshake, shot cooldown, player hit
//               detection and a registered pixel layer for the VGA mux.
// Options     : ENEMY_BULLET_AIMED_SHOT_EN - bullets drift one pixel per
//               frame toward the player x captured at fire time.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_bullet_pool
    import enemy_bullet_pkg::*;
#(
    parameter int      NUM_SLOTS = 4,
    parameter int      BULLET_W  = 4,
    parameter int      BULLET_H  = 12,
    parameter int      PLAYER_W  = 32,
    parameter int      PLAYER_H  = 32,
    parameter int      SCREEN_W  = c_SCREEN_W,
    parameter int      SCREEN_H  = c_SCREEN_H,
    parameter int      SPEED     = 2,
    parameter int      COOLDOWN  = 30,
    parameter rgb444_t COLOR     = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        fire_req,
    input  logic [9:0]  fire_x,
    input  logic [9:0]  fire_y,
    output logic        fire_ack,
    input  logic [9:0]  p_x,
    input  logic [9:0]  p_y,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic        bullet_en,
    output logic [11:0] bullet_rgb,
    output logic        player_hit,
    output logic [3:0]  active_cnt
);

    localparam int c_CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    logic [NUM_SLOTS-1:0] w_valid;
    logic [NUM_SLOTS-1:0] w_hit;
    logic [NUM_SLOTS-1:0] w_pix_on;
    logic [NUM_SLOTS-1:0] w_load_sel;
    logic [NUM_SLOTS-1:0] w_load;
    logic                 w_any_free;
    logic                 w_consume;
    logic                 w_coord_ok;
    logic                 w_accept;
    logic [3:0]           w_popcnt;

    logic                 r_fire_ack;
    logic [c_CD_W-1:0]    r_cooldown;
    logic                 r_bullet_en;
    rgb444_t              r_bullet_rgb;
    logic                 r_player_hit;
    logic [3:0]           r_active_cnt;

`ifdef ENEMY_BULLET_AIMED_SHOT_EN
    logic [1:0]           w_load_dx;

    // Drift direction is the sign of (player x - spawn x) at fire time.
    always_comb begin
        w_load_dx = 2'b00;
        if (p_x > fire_x)      w_load_dx = 2'b01;
        else if (p_x < fire_x) w_load_dx = 2'b11;
    end
`endif

    // Lowest-index free slot, judged on valid bits at the start of the cycle
    // so a slot retiring this cycle is not handed out until the next one.
    always_comb begin
        w_load_sel = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_valid[i] && !w_any_free) begin
                w_load_sel[i] = 1'b1;
                w_any_free    = 1'b1;
            end
        end
    end

    // A request is consumed once per handshake; out-of-range coordinates are
    // acknowledged but dropped without touching a slot or the cooldown.
    always_comb begin
        w_consume  = fire_req && !r_fire_ack && (r_cooldown == '0) && w_any_free;
        w_coord_ok = ({1'b0, fire_y} < 11'(SCREEN_H)) &&
                     ({1'b0, fire_x} <= 11'(SCREEN_W - BULLET_W));
        w_accept   = w_consume && w_coord_ok;
        w_load     = w_load_sel & {NUM_SLOTS{w_accept}};
    end

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            bullet_slot #(
                .BULLET_W (BULLET_W),
                .BULLET_H (BULLET_H),
                .PLAYER_W (PLAYER_W),
                .PLAYER_H (PLAYER_H),
                .SCREEN_W (SCREEN_W),
                .SCREEN_H (SCREEN_H),
                .SPEED    (SPEED)
            ) u_slot (
                .clk          (clk),
                .rst          (rst),
                .i_frame_tick (frame_tick),
                .i_load       (w_load[g]),
                .i_load_x     (fire_x),
                .i_load_y     (fire_y),
`ifdef ENEMY_BULLET_AIMED_SHOT_EN
                .i_load_dx    (w_load_dx),
`endif
                .i_p_x        (p_x),
                .i_p_y        (p_y),
                .i_pix_x      (pix_x),
                .i_pix_y      (pix_y),
                .o_valid      (w_valid[g]),
                .o_hit        (w_hit[g]),
                .o_pix_on     (w_pix_on[g])
            );
        end
    endgenerate

    // Number of live slots.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_popcnt = w_popcnt + 4'(w_valid[i]);
        end
    end

    // Handshake and cooldown: a fresh shot reloads the cooldown, otherwise
    // it counts down one step per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fire_ack <= 1'b0;
            r_cooldown <= '0;
        end else begin
            r_fire_ack <= w_consume;
            if (w_accept) begin
                r_cooldown <= c_CD_W'(COOLDOWN);
            end else if (frame_tick && (r_cooldown != '0)) begin
                r_cooldown <= r_cooldown - c_CD_W'(1);
            end
        end
    end

    // Registered pixel layer, hit pulse and live count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bullet_en  <= 1'b0;
            r_bullet_rgb <= '0;
            r_player_hit <= 1'b0;
            r_active_cnt <= '0;
        end else begin
            r_bullet_en  <= |w_pix_on;
            r_bullet_rgb <= (|w_pix_on) ? COLOR : '0;
            r_player_hit <= |w_hit;
            r_active_cnt <= w_popcnt;
        end
    end

    assign fire_ack   = r_fire_ack;
    assign bullet_en  = r_bullet_en;
    assign bullet_rgb = r_bullet_rgb;
    assign player_hit = r_player_hit;
    assign active_cnt = r_active_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enemy_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_bullet_pool
// Description : Self-checking bench for enemy_bullet_pool (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_bullet_pool;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        fire_req;
    logic [9:0]  fire_x;
    logic [9:0]  fire_y;
    logic        fire_ack;
    logic [9:0]  p_x;
    logic [9:0]  p_y;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        bullet_en;
    logic [11:0] bullet_rgb;
    logic        player_hit;
    logic [3:0]  active_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int       grp;
        logic [9:0] px;
        logic [9:0] py;
        logic     en;
    } pix_vec_t;

    pix_vec_t vecs[15];
    logic     exp_q[$];

    enemy_bullet_pool dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .fire_req   (fire_req),
        .fire_x     (fire_x),
        .fire_y     (fire_y),
        .fire_ack   (fire_ack),
        .p_x        (p_x),
        .p_y        (p_y),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .bullet_en  (bullet_en),
        .bullet_rgb (bullet_rgb),
        .player_hit (player_hit),
        .active_cnt (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        fire_req   = 1'b0;
        frame_tick = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    // Raise a request and expect it consumed on the first edge.
    task automatic fire_now(input string nm, input int x, input int y);
        fire_x   = 10'(x);
        fire_y   = 10'(y);
        fire_req = 1'b1;
        step();
        check(nm, int'(fire_ack), 1);
        fire_req = 1'b0;
        step();
    endtask

    // Tick with the request held; report which tick (and which edge of that
    // tick/gap pair) delivered the ack. n_tick = 0 means none in budget.
    task automatic tick_wait_ack(input int max_ticks, output int n_tick, output int ph);
        n_tick = 0;
        ph     = -1;
        for (int t = 1; t <= max_ticks; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (fire_ack) begin
                n_tick = t; ph = 0; fire_req = 1'b0; return;
            end
            step();
            if (fire_ack) begin
                n_tick = t; ph = 1; fire_req = 1'b0; return;
            end
        end
    endtask

    // Drive a scan position and queue the expected layer output one cycle on.
    task automatic pix_probe(input logic [9:0] x, input logic [9:0] y, input logic e);
        logic ex;
        pix_x = x;
        pix_y = y;
        exp_q.push_back(e);
        step();
        ex = exp_q.pop_front();
        check($sformatf("pix_en(%0d,%0d)", x, y), int'(bullet_en), int'(ex));
        check($sformatf("pix_rgb(%0d,%0d)", x, y), int'(bullet_rgb), ex ? 12'hF00 : 0);
    endtask

    task automatic run_group(input int grp);
        for (int i = 0; i < $size(vecs); i++) begin
            if (vecs[i].grp == grp) pix_probe(vecs[i].px, vecs[i].py, vecs[i].en);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ack"}, int'(fire_ack), 0);
        check({nm, "_en"},  int'(bullet_en), 0);
        check({nm, "_rgb"}, int'(bullet_rgb), 0);
        check({nm, "_hit"}, int'(player_hit), 0);
        check({nm, "_cnt"}, int'(active_cnt), 0);
    endtask

    initial begin
        int  n;
        int  ph;
        logic seen;

        // group 0: bullet at (100,70); group 1: bullets at (100,62) and (200,10);
        // group 2: bullet at (636,479)
        vecs[0]  = '{0, 10'd101, 10'd75, 1'b1};
        vecs[1]  = '{0, 10'd104, 10'd75, 1'b0};
        vecs[2]  = '{0, 10'd100, 10'd70, 1'b1};
        vecs[3]  = '{0, 10'd100, 10'd69, 1'b0};
        vecs[4]  = '{0, 10'd103, 10'd81, 1'b1};
        vecs[5]  = '{0, 10'd103, 10'd82, 1'b0};
        vecs[6]  = '{0, 10'd99,  10'd75, 1'b0};
        vecs[7]  = '{1, 10'd100, 10'd62, 1'b1};
        vecs[8]  = '{1, 10'd100, 10'd61, 1'b0};
        vecs[9]  = '{1, 10'd200, 10'd10, 1'b1};
        vecs[10] = '{1, 10'd200, 10'd9,  1'b0};
        vecs[11] = '{1, 10'd203, 10'd21, 1'b1};
        vecs[12] = '{2, 10'd639, 10'd479, 1'b1};
        vecs[13] = '{2, 10'd635, 10'd479, 1'b0};
        vecs[14] = '{2, 10'd636, 10'd478, 1'b0};

        rst = 1'b1; frame_tick = 1'b0; fire_req = 1'b0;
        fire_x = '0; fire_y = '0; p_x = 10'd500; p_y = 10'd0;
        pix_x = '0; pix_y = '0;
        repeat (2) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // First shot, ten frames of fall, pixel layer at (100,70)
        fire_now("ack_first", 100, 50);
        check("ack_one_pulse", int'(fire_ack), 0);
        check("cnt_after_first", int'(active_cnt), 1);
        repeat (10) tick();
        run_group(0);

        // Cooldown: 20 of its 30 frames remain; ack lands on the gap after the last
        fire_x = 10'd200; fire_y = 10'd50; fire_req = 1'b1;
        tick_wait_ack(25, n, ph);
        check("cooldown_tick", n, 20);
        check("cooldown_edge", ph, 1);

        // Fill the pool
        fire_x = 10'd300; fire_req = 1'b1;
        tick_wait_ack(35, n, ph);
        check("third_tick", n, 30);
        fire_x = 10'd400; fire_req = 1'b1;
        tick_wait_ack(35, n, ph);
        check("fourth_tick", n, 30);
        step();
        check("cnt_full", int'(active_cnt), 4);

        // Pool full: waits until the oldest bullet (y=300) falls off at tick 90
        fire_x = 10'd550; fire_req = 1'b1;
        tick_wait_ack(35, n, ph);
        check("full_no_ack", n, 0);
        tick_wait_ack(120, n, ph);
        check("refill_tick", n, 90);
        check("refill_edge", ph, 1);
        check("cnt_after_free", int'(active_cnt), 3);
        step();
        check("cnt_refilled", int'(active_cnt), 4);

        // Off-screen retire with the player overlapping the would-be position
        do_reset();
        p_x = 10'd96; p_y = 10'd460;
        fire_now("ack_478", 100, 478);
        check("cnt_478", int'(active_cnt), 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("offscreen_hit_a", int'(player_hit), 0);
        step();
        check("offscreen_hit_b", int'(player_hit), 0);
        check("offscreen_cnt", int'(active_cnt), 0);

        // Player hit: p=(96,80), bullet from (100,60) hits when y_new = 70 (5th tick)
        do_reset();
        p_x = 10'd96; p_y = 10'd80;
        fire_now("ack_hit", 100, 60);
        seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            seen = seen | player_hit;
            step();
            seen = seen | player_hit;
        end
        check("no_early_hit", int'(seen), 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("hit_pulse", int'(player_hit), 1);
        check("hit_cnt_lag", int'(active_cnt), 1);
        step();
        check("hit_pulse_end", int'(player_hit), 0);
        check("hit_cnt", int'(active_cnt), 0);

        // Discards: acked, nothing loaded, cooldown untouched
        do_reset();
        p_x = 10'd500; p_y = 10'd0;
        fire_now("ack_disc_y", 100, 480);
        check("cnt_disc_y", int'(active_cnt), 0);
        fire_now("ack_disc_x", 637, 50);
        check("cnt_disc_x", int'(active_cnt), 0);
        fire_now("ack_edge_ok", 636, 479);
        check("cnt_edge_ok", int'(active_cnt), 1);
        run_group(2);

        // Fire and tick together: live bullet moves, new one keeps fire_y
        do_reset();
        fire_now("ack_sim_a", 100, 0);
        repeat (30) tick();
        fire_x = 10'd200; fire_y = 10'd10; fire_req = 1'b1; frame_tick = 1'b1;
        step();
        check("ack_sim_b", int'(fire_ack), 1);
        fire_req = 1'b0; frame_tick = 1'b0;
        step();
        run_group(1);

        // Reset mid-flight
        pix_x = 10'd200; pix_y = 10'd10;
        step();
        check("pre_rst_en", int'(bullet_en), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        check_all_zero("rst_edge");
        rst = 1'b0;
        step();
        step();
        check("post_rst_en", int'(bullet_en), 0);
        check("post_rst_cnt", int'(active_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
